retry_inorder_start: RTL and testbench

// Head of an in-order retry loop, upstream of retry_inorder_end. Tags each element with a sequential
// ID and issues it into the protected pipeline.

---
 rtl/retry_inorder_start.sv | 63 ++++++
 tb/tb_retry_inorder_start.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/retry_inorder_start.sv
// rtl/retry_inorder_start.sv - head of an in-order retry loop: ID tagging, replay buffer, lock stall
module retry_inorder_start #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [IDSize-1:0] retry_id_o,
  input  logic [IDSize-1:0] retry_id_i,
  input  logic              retry_valid_i,
  output logic              retry_ready_o,
  input  logic              retry_lock_i
);

  localparam int unsigned Depth = 2 ** IDSize;

  logic [IDSize-1:0] id_q;
  DataType           buf_q [Depth];
  logic              issue;

  // Replay beats new elements; lock only blocks the upstream path, never a replay.
  always_comb begin
    data_o        = data_i;
    valid_o       = 1'b0;
    ready_o       = 1'b0;
    retry_ready_o = 1'b0;
    if (!rst_i) begin
      if (retry_valid_i) begin
        data_o        = buf_q[retry_id_i];
        valid_o       = 1'b1;
        retry_ready_o = ready_i;
      end else if (!retry_lock_i) begin
        valid_o = valid_i;
        ready_o = ready_i;
      end
    end
  end

  assign issue      = valid_o & ready_i;
  assign id_o       = id_q;
  assign retry_id_o = id_q;

  // Every issue, replay or new, consumes a fresh ID and refreshes that ID's slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        buf_q[i] <= '0;
      end
    end else if (issue) begin
      buf_q[id_q] <= data_o;
      id_q        <= id_q + IDSize'(1);
    end
  end

endmodule

// File: tb/tb_retry_inorder_start.sv
// tb/tb_retry_inorder_start.sv - randomized self-checking bench for retry_inorder_start
module tb_retry_inorder_start;

  localparam int IDW   = 2;
  localparam int DEPTH = 4;
  typedef logic [7:0] data_t;

  logic           clk = 1'b0;
  logic           rst;
  data_t          data_i;
  logic           valid_i;
  logic           ready_o;
  data_t          data_o;
  logic [IDW-1:0] id_o;
  logic           valid_o;
  logic           ready_i;
  logic [IDW-1:0] retry_id_o;
  logic [IDW-1:0] retry_id_i;
  logic           retry_valid_i;
  logic           retry_ready_o;
  logic           retry_lock_i;

  int    errors = 0;
  int    checks = 0;
  data_t log_q[$];
  data_t ed;
  logic  ev, er, err;

  always #5 clk = ~clk;

  retry_inorder_start #(.DataType(data_t), .IDSize(IDW)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .id_o(id_o), .valid_o(valid_o), .ready_i(ready_i),
    .retry_id_o(retry_id_o), .retry_id_i(retry_id_i), .retry_valid_i(retry_valid_i),
    .retry_ready_o(retry_ready_o), .retry_lock_i(retry_lock_i)
  );

  // Slot content = most recent issued element whose issue index maps onto that ID.
  function automatic data_t slot_value(input int id);
    for (int i = log_q.size() - 1; i >= 0; i--)
      if (i % DEPTH == id) return log_q[i];
    return '0;
  endfunction

  function automatic int next_id();
    return log_q.size() % DEPTH;
  endfunction

  task automatic predict();
    if (retry_valid_i) begin
      ed = slot_value(int'(retry_id_i)); ev = 1'b1; er = 1'b0; err = ready_i;
    end else if (retry_lock_i) begin
      ed = data_i; ev = 1'b0; er = 1'b0; err = 1'b0;
    end else begin
      ed = data_i; ev = valid_i; er = ready_i; err = 1'b0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (ev && ready_i) log_q.push_back(ed);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; ready_i = 1'b1; data_i = '0;
    retry_valid_i = 1'b0; retry_id_i = '0; retry_lock_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; ready_i = 1'b1; data_i = 8'($urandom);
    retry_valid_i = 1'b1; retry_id_i = 2'd1; retry_lock_i = 1'b0;
    @(negedge clk); #1;
    checks += 5;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid_o: got %0b expected 0", valid_o); end
    if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_o: got %0b expected 0", ready_o); end
    if (retry_ready_o !== 1'b0) begin errors++; $display("FAIL reset_retry_ready_o: got %0b expected 0", retry_ready_o); end
    if (id_o !== 2'd0) begin errors++; $display("FAIL reset_id_o: got %0d expected 0", id_o); end
    if (retry_id_o !== 2'd0) begin errors++; $display("FAIL reset_retry_id_o: got %0d expected 0", retry_id_o); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_streaming();
    data_t d [3];
    do_reset();
    for (int k = 0; k < 3; k++) begin
      d[k] = 8'($urandom); data_i = d[k]; valid_i = 1'b1; ready_i = 1'b1;
      #1; predict();
      checks += 4;
      if (id_o !== 2'(k)) begin errors++; $display("FAIL stream_id_o[%0d]: got %0d expected %0d", k, id_o, k); end
      if (data_o !== d[k]) begin errors++; $display("FAIL stream_data_o[%0d]: got %0h expected %0h", k, data_o, d[k]); end
      if (valid_o !== 1'b1) begin errors++; $display("FAIL stream_valid_o[%0d]: got %0b expected 1", k, valid_o); end
      if (ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready_o[%0d]: got %0b expected 1", k, ready_o); end
      advance();
    end
    valid_i = 1'b0; #1;
    checks++;
    if (retry_id_o !== 2'd3) begin errors++; $display("FAIL stream_retry_id_o: got %0d expected 3", retry_id_o); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dut.buf_q[k] !== d[k]) begin errors++; $display("FAIL stream_buf[%0d]: got %0h expected %0h", k, dut.buf_q[k], d[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_replay_priority();
    data_t a, dd;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      data_i = 8'($urandom); valid_i = 1'b1; ready_i = 1'b1;
      if (k == 0) a = data_i;
      #1; predict(); advance();
    end
    dd = 8'($urandom); data_i = dd; valid_i = 1'b1;
    retry_valid_i = 1'b1; retry_id_i = 2'd0;
    #1; predict();
    checks += 5;
    if (data_o !== a) begin errors++; $display("FAIL prio_data_o: got %0h expected %0h", data_o, a); end
    if (id_o !== 2'd2) begin errors++; $display("FAIL prio_id_o: got %0d expected 2", id_o); end
    if (retry_ready_o !== 1'b1) begin errors++; $display("FAIL prio_retry_ready_o: got %0b expected 1", retry_ready_o); end
    if (ready_o !== 1'b0) begin errors++; $display("FAIL prio_ready_o: got %0b expected 0", ready_o); end
    if (valid_o !== 1'b1) begin errors++; $display("FAIL prio_valid_o: got %0b expected 1", valid_o); end
    advance();
    retry_valid_i = 1'b0;
    #1; predict();
    checks += 3;
    if (data_o !== dd) begin errors++; $display("FAIL prio_next_data_o: got %0h expected %0h", data_o, dd); end
    if (id_o !== 2'd3) begin errors++; $display("FAIL prio_next_id_o: got %0d expected 3", id_o); end
    if (ready_o !== 1'b1) begin errors++; $display("FAIL prio_next_ready_o: got %0b expected 1", ready_o); end
    advance();
    valid_i = 1'b0;
  endtask

  task automatic test_lock_stall();
    data_t dd;
    int    id0;
    dd = 8'($urandom); data_i = dd; valid_i = 1'b1; ready_i = 1'b1; retry_lock_i = 1'b1;
    id0 = next_id();
    for (int c = 0; c < 5; c++) begin
      #1; predict();
      checks += 3;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL lock_valid_o[%0d]: got %0b expected 0", c, valid_o); end
      if (ready_o !== 1'b0) begin errors++; $display("FAIL lock_ready_o[%0d]: got %0b expected 0", c, ready_o); end
      if (retry_id_o !== 2'(id0)) begin errors++; $display("FAIL lock_retry_id_o[%0d]: got %0d expected %0d", c, retry_id_o, id0); end
      advance();
    end
    retry_lock_i = 1'b0;
    #1; predict();
    checks += 3;
    if (valid_o !== 1'b1 || ready_o !== 1'b1) begin errors++; $display("FAIL unlock_handshake: got valid=%0b ready=%0b expected 1/1", valid_o, ready_o); end
    if (data_o !== dd) begin errors++; $display("FAIL unlock_data_o: got %0h expected %0h", data_o, dd); end
    if (id_o !== 2'(id0)) begin errors++; $display("FAIL unlock_id_o: got %0d expected %0d", id_o, id0); end
    advance();
    valid_i = 1'b0;
  endtask

  task automatic test_wrap_and_backpressure();
    data_t e [6];
    int    idb;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      e[k] = 8'((k << 5) | $urandom_range(0, 31));
      data_i = e[k]; valid_i = 1'b1; ready_i = 1'b1;
      #1; predict();
      checks++;
      if (id_o !== 2'(k % DEPTH)) begin errors++; $display("FAIL wrap_id_o[%0d]: got %0d expected %0d", k, id_o, k % DEPTH); end
      advance();
    end
    valid_i = 1'b0; retry_valid_i = 1'b1; retry_id_i = 2'd0;
    #1; predict();
    checks += 2;
    if (data_o !== e[4]) begin errors++; $display("FAIL wrap_replay_data_o: got %0h expected %0h", data_o, e[4]); end
    if (id_o !== 2'd2) begin errors++; $display("FAIL wrap_replay_id_o: got %0d expected 2", id_o); end
    advance();
    retry_id_i = 2'd1; ready_i = 1'b0;
    idb = next_id();
    for (int c = 0; c < 3; c++) begin
      #1; predict();
      checks += 4;
      if (retry_ready_o !== 1'b0) begin errors++; $display("FAIL bp_retry_ready_o[%0d]: got %0b expected 0", c, retry_ready_o); end
      if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_o[%0d]: got %0b expected 1", c, valid_o); end
      if (data_o !== e[5]) begin errors++; $display("FAIL bp_data_o[%0d]: got %0h expected %0h", c, data_o, e[5]); end
      if (id_o !== 2'(idb)) begin errors++; $display("FAIL bp_id_o[%0d]: got %0d expected %0d", c, id_o, idb); end
      advance();
    end
    ready_i = 1'b1;
    #1; predict();
    checks++;
    if (retry_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_retry_ready_o: got %0b expected 1", retry_ready_o); end
    advance();
    retry_valid_i = 1'b0;
  endtask

  task automatic test_random();
    int sz, age;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      sz = log_q.size();
      ready_i = ($urandom % 4) != 0;
      retry_lock_i = ($urandom % 4) == 0;
      valid_i = $urandom % 2;
      data_i = 8'($urandom);
      retry_valid_i = (sz > 0) && (($urandom % 3) == 0);
      if (retry_valid_i) begin
        age = $urandom_range(1, (sz < DEPTH - 1) ? sz : DEPTH - 1);
        retry_id_i = 2'((sz - age) % DEPTH);
      end
      #1; predict();
      checks += 6;
      if (valid_o !== ev) begin errors++; $display("FAIL rnd_valid_o[%0d]: got %0b expected %0b", c, valid_o, ev); end
      if (ready_o !== er) begin errors++; $display("FAIL rnd_ready_o[%0d]: got %0b expected %0b", c, ready_o, er); end
      if (retry_ready_o !== err) begin errors++; $display("FAIL rnd_retry_ready_o[%0d]: got %0b expected %0b", c, retry_ready_o, err); end
      if (id_o !== 2'(next_id())) begin errors++; $display("FAIL rnd_id_o[%0d]: got %0d expected %0d", c, id_o, next_id()); end
      if (retry_id_o !== 2'(next_id())) begin errors++; $display("FAIL rnd_retry_id_o[%0d]: got %0d expected %0d", c, retry_id_o, next_id()); end
      if (ev && data_o !== ed) begin errors++; $display("FAIL rnd_data_o[%0d]: got %0h expected %0h", c, data_o, ed); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    data_t dd;
    valid_i = 1'b1; ready_i = 1'b1; data_i = 8'($urandom);
    #1; predict(); advance();
    #2; rst = 1'b1; #1;
    checks += 3;
    if (id_o !== 2'd0 || retry_id_o !== 2'd0) begin errors++; $display("FAIL midrst_id: got id=%0d retry_id=%0d expected 0/0", id_o, retry_id_o); end
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid_o: got %0b expected 0", valid_o); end
    if (ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready_o: got %0b expected 0", ready_o); end
    for (int k = 0; k < DEPTH; k++) begin
      checks++;
      if (dut.buf_q[k] !== 8'h00) begin errors++; $display("FAIL midrst_buf[%0d]: got %0h expected 0", k, dut.buf_q[k]); end
    end
    @(negedge clk);
    rst = 1'b0; log_q.delete();
    dd = 8'($urandom); data_i = dd;
    #1; predict();
    checks += 2;
    if (id_o !== 2'd0) begin errors++; $display("FAIL midrst_first_id_o: got %0d expected 0", id_o); end
    if (data_o !== dd) begin errors++; $display("FAIL midrst_first_data_o: got %0h expected %0h", data_o, dd); end
    advance();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_streaming();
    test_replay_priority();
    test_lock_stall();
    test_wrap_and_backpressure();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
